input_memory_reader: RTL and testbench

INPUT_MEMORY_READER -- requirements
Module: input_memory_reader

---
 rtl/nn_mem_pkg.sv | 20 ++
 rtl/input_memory_reader_elem_fifo2.sv | 71 +++++++
 rtl/input_memory_reader.sv | 153 +++++++++++++++
 tb/tb_input_memory_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_mem_pkg.sv
// Shared constants, helpers and FSM state type for the input memory reader.
package nn_mem_pkg;

  localparam int unsigned NN_DEPTH  = 8;
  localparam int unsigned NN_DATA_W = 16;

  // Address width for a given vector depth (at least one bit).
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned NN_ADDR_W = addr_w(NN_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/input_memory_reader_elem_fifo2.sv
// Two-entry in-order element buffer with synchronous flush.
module elem_fifo2 #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] slot0_q, slot0_d;
  logic [DATA_W-1:0] slot1_q, slot1_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push;
  logic              do_pop;

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr_q) slot1_d = push_data;
        else          slot0_d = push_data;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      slot0_q  <= '0;
      slot1_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = rd_ptr_q ? slot1_q : slot0_q;
  assign count     = count_q;

endmodule

// File: rtl/input_memory_reader.sv
// Streams one DEPTH-word vector out of a synchronous-read RAM into a
// valid/ready element interface, keeping at most two words buffered or in
// flight. Optional feature macro: INPUT_READER_STALL_COUNT_EN adds the
// 8-bit saturating stall_cycles output.
module input_memory_reader
  import nn_mem_pkg::*;
#(
  parameter  int unsigned DEPTH  = NN_DEPTH,
  parameter  int unsigned DATA_W = NN_DATA_W,
  localparam int unsigned AW     = addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              start,
  input  logic              abort,
  input  logic              element_ready,
  input  logic [DATA_W-1:0] input_ram_data,
  output logic [AW-1:0]     input_ram_address,
  output logic              input_ram_enable,
  output logic [DATA_W-1:0] active_z,
  output logic              element_valid,
  output logic              last_element,
  output logic              busy,
  output logic              finished
`ifdef INPUT_READER_STALL_COUNT_EN
  ,
  output logic [7:0]        stall_cycles
`endif
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  rd_state_e         state_q, state_d;
  logic [AW:0]       rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]     pop_idx_q, pop_idx_d;
  logic              dv_q, dv_d;

  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_flush;
  logic              elem_vld;
  logic              xfer;
  logic              final_xfer;
  logic              rd_issue;
  logic [2:0]        occ;

  elem_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock     (clock),
    .clear_n   (clear_n),
    .flush     (fifo_flush),
    .push      (dv_q),
    .pop       (xfer),
    .push_data (input_ram_data),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // Read issue: the strobe looks at this cycle's transfer so a new word can be
  // requested the same cycle one is consumed, sustaining one element per cycle.
  always_comb begin
    elem_vld   = (fifo_count != 2'd0);
    xfer       = elem_vld && element_ready;
    final_xfer = xfer && (pop_idx_q == LAST_C);
    occ        = 3'(fifo_count) + 3'(dv_q) - 3'(xfer);
    rd_issue   = (state_q == ST_STREAM) && !abort &&
                 (rd_cnt_q < DEPTH_C) && (occ < 3'd2);
  end

  // FSM next state, read/pop counters and buffer flush control.
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    pop_idx_d  = pop_idx_q;
    dv_d       = rd_issue;
    fifo_flush = 1'b0;
    if (rd_issue) rd_cnt_d  = rd_cnt_q + (AW+1)'(1);
    if (xfer)     pop_idx_d = pop_idx_q + AW'(1);
    if (abort) begin
      state_d    = ST_IDLE;
      rd_cnt_d   = '0;
      pop_idx_d  = '0;
      dv_d       = 1'b0;
      fifo_flush = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d    = ST_STREAM;
            rd_cnt_d   = '0;
            pop_idx_d  = '0;
            fifo_flush = 1'b1;
          end
        end
        ST_STREAM: begin
          if (final_xfer) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and counter registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      pop_idx_q <= '0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      pop_idx_q <= pop_idx_d;
      dv_q      <= dv_d;
    end
  end

  // Output decode from registered state; active_z reads zero when empty.
  always_comb begin
    input_ram_address = rd_cnt_q[AW-1:0];
    input_ram_enable  = rd_issue;
    element_valid     = elem_vld;
    active_z          = elem_vld ? fifo_head : '0;
    last_element      = elem_vld && (pop_idx_q == LAST_C);
    busy              = (state_q == ST_STREAM);
    finished          = (state_q == ST_DONE);
  end

`ifdef INPUT_READER_STALL_COUNT_EN
  logic [7:0] stall_q, stall_d;

  // Saturating count of cycles where an element waits on the consumer.
  always_comb begin
    stall_d = stall_q;
    if (start) begin
      stall_d = 8'd0;
    end else if (elem_vld && !element_ready && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) stall_q <= 8'd0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_input_memory_reader.sv
// Scoreboard bench for input_memory_reader: stimulus pushes expected elements,
// a negedge monitor pops and compares on each transfer and audits RAM reads.
module tb_input_memory_reader;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic              clock = 1'b0;
  logic              clear_n;
  logic              start;
  logic              abort;
  logic              element_ready;
  logic [DATA_W-1:0] input_ram_data;
  logic [2:0]        input_ram_address;
  logic              input_ram_enable;
  logic [DATA_W-1:0] active_z;
  logic              element_valid;
  logic              last_element;
  logic              busy;
  logic              finished;
`ifdef INPUT_READER_STALL_COUNT_EN
  logic [7:0]        stall_cycles;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q = '0;

  exp_t exp_q[$];
  int   total     = 0;
  int   bad       = 0;
  int   rd_issued = 0;
  int   xfer_cnt  = 0;

  input_memory_reader #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clock             (clock),
    .clear_n           (clear_n),
    .start             (start),
    .abort             (abort),
    .element_ready     (element_ready),
    .input_ram_data    (input_ram_data),
    .input_ram_address (input_ram_address),
    .input_ram_enable  (input_ram_enable),
    .active_z          (active_z),
    .element_valid     (element_valid),
    .last_element      (last_element),
    .busy              (busy),
    .finished          (finished)
`ifdef INPUT_READER_STALL_COUNT_EN
    ,
    .stall_cycles      (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM model: data valid the cycle after the strobe.
  always @(posedge clock) begin
    if (input_ram_enable) ram_q <= mem[input_ram_address];
  end
  assign input_ram_data = ram_q;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: read order / window audit and scoreboard pop on each transfer.
  always @(negedge clock) begin
    int   xfer_now;
    exp_t e;
    if (clear_n === 1'b1) begin
      xfer_now = (element_valid && element_ready) ? 1 : 0;
      if (input_ram_enable) begin
        check("rd_addr", int'(input_ram_address), rd_issued);
        check("rd_beyond_last", int'(rd_issued < int'(DEPTH)), 1);
        check("rd_window", int'((rd_issued - xfer_cnt - xfer_now) < 2), 1);
        rd_issued++;
      end
      if (xfer_now != 0) begin
        if (exp_q.size() == 0) begin
          check("extra_element", int'(active_z), -1);
        end else begin
          e = exp_q.pop_front();
          check("elem_data", int'(active_z), int'(e.data));
          check("elem_last", int'(last_element), int'(e.last));
        end
        xfer_cnt++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Load RAM with base + i*step and queue the matching expected elements.
  task automatic begin_stream(input logic [15:0] base, input logic [15:0] step);
    exp_t e;
    exp_q.delete();
    rd_issued = 0;
    xfer_cnt  = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = base + 16'(i) * step;
      e.data = mem[i];
      e.last = (i == int'(DEPTH) - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"},     int'(input_ram_address), 0);
    check({tag, "_en"},       int'(input_ram_enable),  0);
    check({tag, "_z"},        int'(active_z),          0);
    check({tag, "_valid"},    int'(element_valid),     0);
    check({tag, "_last"},     int'(last_element),      0);
    check({tag, "_busy"},     int'(busy),              0);
    check({tag, "_finished"}, int'(finished),          0);
  endtask

  // Full stream with ready high; bounded wait for finished.
  task automatic run_full_stream(input string tag, input logic [15:0] base,
                                 input logic [15:0] step);
    int waited;
    begin_stream(base, step);
    element_ready = 1'b1;
    next_cycle(); start = 1'b1;
    next_cycle(); start = 1'b0;
    waited = 0;
    @(negedge clock);
    while (!finished && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    check({tag, "_finished"}, int'(finished), 1);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_xfers"}, xfer_cnt, int'(DEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    clear_n = 1'b0; start = 1'b0; abort = 1'b0; element_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    clear_n = 1'b1;

    // Nominal stream, ready high, exact cycle timing.
    begin_stream(16'h0100, 16'h0001);
    next_cycle(); start = 1'b1; element_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      next_cycle(); start = 1'b0;
      @(negedge clock);
      if (c == 1) begin
        check("t1_c1_en", int'(input_ram_enable), 1);
        check("t1_c1_addr", int'(input_ram_address), 0);
        check("t1_c1_busy", int'(busy), 1);
      end
      if (c == 2) check("t1_c2_valid", int'(element_valid), 0);
      if (c >= 3 && c <= 10) check("t1_valid", int'(element_valid), 1);
      check("t1_last", int'(last_element), int'(c == 10));
      if (c == 11) begin
        check("t1_c11_finished", int'(finished), 1);
        check("t1_c11_busy", int'(busy), 0);
      end
    end
    check("t1_queue_left", exp_q.size(), 0);

    // Consumer stall on cycles 4..7 holds element 1.
    begin_stream(16'h0100, 16'h0001);
    next_cycle(); start = 1'b1; element_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      next_cycle(); start = 1'b0;
      element_ready = !(c >= 4 && c <= 7);
      @(negedge clock);
      if (c >= 4 && c <= 7) begin
        check("t2_hold_z", int'(active_z), 16'h0101);
        check("t2_hold_valid", int'(element_valid), 1);
      end
    end
    waited = 0;
    while (!finished && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    check("t2_finished", int'(finished), 1);
    check("t2_queue_left", exp_q.size(), 0);
    check("t2_xfers", xfer_cnt, int'(DEPTH));

    // Abort at cycle 5, then replay a new pattern from address 0.
    begin_stream(16'hF000, 16'h0111);
    next_cycle(); start = 1'b1; element_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      next_cycle(); start = 1'b0;
      abort = (c == 5);
      @(negedge clock);
    end
    next_cycle(); abort = 1'b0;
    @(negedge clock);
    check_idle_outputs("t3_abort");
    run_full_stream("t3_replay", 16'h1234, 16'h0F0F);

    // Reset asserted at cycle 6 mid-stream, then a clean full vector.
    begin_stream(16'h8001, 16'h2222);
    next_cycle(); start = 1'b1; element_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      next_cycle(); start = 1'b0;
      @(negedge clock);
    end
    next_cycle(); clear_n = 1'b0;
    #1;
    check_idle_outputs("t4_reset");
    next_cycle(); clear_n = 1'b1;
    run_full_stream("t4_restart", 16'h0AB0, 16'h0003);

    // Start pulses during stream and on the final transfer are ignored.
    begin_stream(16'h7FF8, 16'h0001);
    next_cycle(); start = 1'b1; element_ready = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      start = (c == 5 || c == 10);
      @(negedge clock);
      if (c == 10) check("t5_c10_last", int'(last_element), 1);
      if (c == 11) check("t5_c11_finished", int'(finished), 1);
      if (c == 14) begin
        check("t5_c14_finished", int'(finished), 1);
        check("t5_c14_valid", int'(element_valid), 0);
      end
    end
    start = 1'b0;
    check("t5_queue_left", exp_q.size(), 0);
    check("t5_reads", rd_issued, int'(DEPTH));

`ifdef INPUT_READER_STALL_COUNT_EN
    // Long stall saturates the counter; start clears it.
    begin_stream(16'h0100, 16'h0001);
    next_cycle(); start = 1'b1; element_ready = 1'b0;
    for (int c = 1; c <= 310; c++) begin
      next_cycle(); start = 1'b0;
    end
    @(negedge clock);
    check("t6_stall_sat", int'(stall_cycles), 255);
    next_cycle(); start = 1'b1;
    next_cycle(); start = 1'b0;
    check("t6_stall_clear", int'(stall_cycles), 0);
    abort = 1'b1;
    next_cycle(); abort = 1'b0; element_ready = 1'b1;
    @(negedge clock);
    check("t6_abort_valid", int'(element_valid), 0);
`endif

    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
